// File: rtl/uart_pkg.sv
// Shared constants for the UART receive port: register offsets, STAT bit
// positions and the receive FSM state encoding.
package uart_pkg;

  localparam logic [31:0] OFF_DATA = 32'd0;
  localparam logic [31:0] OFF_STAT = 32'd4;

  localparam int STAT_NE   = 0;
  localparam int STAT_OVR  = 1;
  localparam int STAT_FERR = 2;
  localparam int STAT_IE   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Byte FIFO with wrap-around pointers; a push into a full FIFO only lands
// when a pop frees a slot in the same cycle, otherwise it is dropped.
module rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rptr];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped UART receiver: synchronized rx, mid-bit sampling FSM, byte
// FIFO, DATA/STAT registers and a registered receive interrupt.
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int          DIV   = 2604,
  parameter int          DEPTH = 4,
  parameter logic [31:0] BASE  = 32'h40000018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(DIV);

  rx_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_sync1, r_sync2, r_rx_prev, r_armed;
  logic [1:0]    r_vld;
  logic          r_ie, r_ferr, r_ovr;
  logic          w_rx, w_fall, w_expire, w_push, w_ferr_set, w_ovr_set;
  logic          w_hit_data, w_hit_stat, w_wr_stat, w_pop;
  logic          w_full, w_empty;
  logic [7:0]    w_dout;
  logic          w_unused;

  assign w_unused = ^{wdata[31:4], wdata[0]};
  assign w_rx     = r_sync2;
  assign w_expire = (r_cnt == CW'(1));
  // Start detection waits until a genuine high has been seen after reset, so
  // the reset-forced synchronizer ones never fake an idle line.
  assign w_fall   = r_armed && r_rx_prev && !w_rx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_vld     <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= w_rx;
      r_vld     <= {r_vld[0], 1'b1};
      if (r_vld[1] && w_rx) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = HALF;
        end
      end
      ST_START: begin
        if (w_expire) begin
          if (!w_rx) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = FULL;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_cnt_nxt   = FULL;
          w_bit_nxt   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_expire) begin
          w_state_nxt = ST_IDLE;
          w_push      = w_rx;
          w_ferr_set  = !w_rx;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_shift),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_hit_data = rd && (addr == BASE + OFF_DATA);
  assign w_hit_stat = rd && (addr == BASE + OFF_STAT);
  assign w_wr_stat  = wr && (addr == BASE + OFF_STAT);
  assign w_pop      = w_hit_data && !w_empty;
  assign w_ovr_set  = w_push && w_full && !w_pop;

  always_comb begin
    rdata = 32'd0;
    if (w_hit_data && !w_empty) begin
      rdata = {24'd0, w_dout};
    end else if (w_hit_stat) begin
      rdata[STAT_IE]   = r_ie;
      rdata[STAT_FERR] = r_ferr;
      rdata[STAT_OVR]  = r_ovr;
      rdata[STAT_NE]   = !w_empty;
    end
  end

  // A flag set in the same cycle as its write-1-clear wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ie   <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (w_wr_stat) r_ie <= wdata[STAT_IE];
      if (w_ferr_set)                        r_ferr <= 1'b1;
      else if (w_wr_stat && wdata[STAT_FERR]) r_ferr <= 1'b0;
      if (w_ovr_set)                         r_ovr <= 1'b1;
      else if (w_wr_stat && wdata[STAT_OVR])  r_ovr <= 1'b0;
      irq <= r_ie && !w_empty;
    end
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port at 16 clk per bit with a byte scoreboard
// filled as frames are driven and drained on DATA reads.
module tb_uart_rx_port;

  localparam int          DIV    = 16;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] BASE   = 32'h40000018;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        reset, rx, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rv;

  // Clock and DUT
  always #5 clk = ~clk;

  uart_rx_port #(.DIV(DIV), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    @(posedge clk);
    #1 rd = 1'b0; addr = 32'd0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 wr = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic read_stat(input string tag, input logic [31:0] expv);
    logic [31:0] d;
    bus_read(A_STAT, d);
    check(tag, d, expv);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d;
    logic [31:0] expv;
    expv = 32'd0;
    if (exp_q.size() > 0) expv = {24'd0, exp_q.pop_front()};
    bus_read(A_DATA, d);
    check(tag, d, expv);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok && exp_q.size() < DEPTH) exp_q.push_back(b);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(DIV);
    end
    rx = stop_ok;
    tick(DIV);
    rx = 1'b1;
    tick(4);
  endtask

  initial begin
    reset = 1'b0; rx = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    tick(3);
    @(negedge clk);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    reset = 1'b1;
    tick(4);
    read_stat("post_reset_stat", 32'h0);
    read_data("post_reset_data_empty");

    // Basic frame, bus decode and DATA-write ignore
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("no_hit_rdata", rdata, 32'd0);
    bus_read(BASE + 32'd8, rv);
    check("other_addr_rdata", rv, 32'd0);
    bus_write(A_DATA, 32'hFF);
    read_stat("a5_stat_ne", 32'h1);
    read_data("a5_data");
    read_stat("a5_stat_empty", 32'h0);

    // Interrupt enable and irq timing around a pop
    bus_write(A_STAT, 32'h8);
    tick(2);
    check("irq_idle_ie", {31'd0, irq}, 32'd0);
    send_byte(8'h3C, 1'b1);
    check("irq_rise", {31'd0, irq}, 32'd1);
    read_data("3c_data");
    check("irq_hold_at_pop", {31'd0, irq}, 32'd1);
    tick(1);
    check("irq_fall", {31'd0, irq}, 32'd0);
    bus_write(A_STAT, 32'h0);

    // Overflow: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    read_stat("ovr_stat", 32'h3);
    for (int i = 0; i < 4; i++) read_data("ovr_data");
    read_data("ovr_fifth_read_zero");
    bus_write(A_STAT, 32'h2);
    read_stat("ovr_cleared", 32'h0);

    // Framing error
    send_byte(8'h55, 1'b0);
    tick(DIV);
    read_stat("ferr_stat", 32'h4);
    bus_write(A_STAT, 32'h4);
    read_stat("ferr_cleared", 32'h0);

    // Start-bit glitch then a good frame
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(12);
    read_stat("glitch_stat", 32'h0);
    send_byte(8'h7E, 1'b1);
    read_data("7e_data");
    read_stat("7e_stat_empty", 32'h0);

    // Reset in mid-frame with data queued and IE set
    bus_write(A_STAT, 32'h8);
    send_byte(8'h99, 1'b1);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    rx = 1'b0;
    tick(DIV);
    rx = 1'b1;
    tick(2 * DIV);
    rx = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    exp_q.delete();
    check("midreset_irq", {31'd0, irq}, 32'd0);
    check("midreset_rdata", rdata, 32'd0);
    bus_read(A_STAT, rv);
    check("midreset_stat", rv, 32'd0);
    reset = 1'b1;
    tick(20);
    rx = 1'b1;
    tick(4);
    read_stat("low_line_no_start", 32'h0);
    read_data("after_reset_empty");
    send_byte(8'h81, 1'b1);
    check("after_reset_irq_off", {31'd0, irq}, 32'd0);
    read_data("81_data");
    read_stat("81_stat_empty", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_port.md
UART_RX_PORT -- requirements
Module: uart_rx_port

Interface
REQ-001 SHALL have parameter DIV, default 2604, meaning clk cycles per UART bit (9600 baud at 25 MHz); legal values are 4 or more.
REQ-002 SHALL have parameter DEPTH, default 4, meaning receive FIFO entries; the value SHALL be a power of 2.
REQ-003 SHALL have parameter BASE, default 32'h40000018, meaning the address of the DATA register; the STAT register is at BASE+4.
REQ-004 Ports, clock and reset first:
  clk    in   1   single clock; all state changes on posedge clk
  reset  in   1   synchronous, active-low reset
  rx     in   1   asynchronous UART serial input, idle high
  rd     in   1   bus read strobe, one cycle per load
  wr     in   1   bus write strobe, one cycle per store
  addr   in   32  bus byte address
  wdata  in   32  bus write data
  rdata  out  32  bus read data, combinational
  irq    out  1   receive interrupt request

Function
REQ-005 rx SHALL pass through a 2-flop synchronizer; all receive logic SHALL use only the synchronized value.
REQ-006 The receive FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-007 IDLE: a synchronized-rx 1->0 transition SHALL load the bit counter with DIV/2 and go to START.
REQ-008 START: on counter expiry, if rx is 0 SHALL go to DATA with the counter reloaded to DIV; if rx is 1 (glitch) SHALL return to IDLE with nothing pushed and no error flag set.
REQ-009 DATA: SHALL sample rx on each DIV expiry and shift it in LSB first; after the 8th sample SHALL go to STOP.
REQ-010 STOP: on DIV expiry, rx=1 SHALL push the byte to the FIFO; rx=0 SHALL set FERR and discard the byte; in both cases the FSM SHALL go to IDLE in the same cycle, so a following start edge is accepted immediately.
REQ-011 The FIFO SHALL have DEPTH entries, a wrap-around read pointer and write pointer, and a count that is 0..DEPTH.
REQ-012 A push into a full FIFO with no pop in the same cycle SHALL drop the byte, set OVR, and leave the FIFO contents unchanged.
REQ-013 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full or empty-with-push; count SHALL be unchanged when the FIFO is full.
REQ-014 A read hit on DATA is rd=1 and addr==BASE. It SHALL drive rdata={24'd0, head byte} and pop the FIFO at the clock edge. When the FIFO is empty it SHALL drive rdata=0 and not pop.
REQ-015 A read hit on STAT is rd=1 and addr==BASE+4. It SHALL drive rdata={28'd0, IE, FERR, OVR, NE}, where NE means count!=0; it SHALL have no side effects.
REQ-016 rdata SHALL be 32'd0 whenever there is no read hit, so that the bus can OR it with other responders.
REQ-017 A write to STAT SHALL set IE=wdata[3] and SHALL clear FERR if wdata[2]=1 and OVR if wdata[1]=1. A write to DATA SHALL be ignored.
REQ-018 If a flag set (REQ-010, REQ-012) and its write-1-clear (REQ-017) occur in the same cycle, the set SHALL win.
REQ-019 irq SHALL be registered and equal to IE && NE, one cycle after either changes.
REQ-020 Bus accesses SHALL never stall or disturb the receive FSM.

Reset
REQ-021 When reset=0 at a clk edge, the block SHALL set FSM=IDLE, clear counters, pointers and count, set IE=FERR=OVR=0 and irq=0, and set both synchronizer flops to 1.
REQ-022 Reset asserted in the middle of a frame SHALL abandon that frame.
REQ-023 After reset, rx SHALL have to go high and then fall again before any reception starts; a line still low at reset release SHALL NOT be taken as a start bit.

Structure
REQ-024 The register offsets (DATA=0, STAT=4), the STAT bit positions and the FSM state encoding SHALL be constants in a shared package, uart_pkg.
REQ-025 The FIFO SHALL be a sub-module named rx_fifo with ports push, pop, din, dout, full and empty; its push/pop rules SHALL be those of REQ-012 and REQ-013.

Verification (bench uses DIV=16)
REQ-026 Send frame 0xA5 at 16 clk per bit, then read STAT then DATA -> STAT=0x1 (NE=1), DATA=0x000000A5, then STAT=0x0.
REQ-027 Write STAT=0x8, then send 0x3C -> irq rises within 2 clk after the stop-bit sample; a DATA read returns 0x3C and irq falls on the next clk.
REQ-028 Send 5 frames 0x01..0x05 with no reads -> OVR=1; four DATA reads return 0x01..0x04; a fifth read returns 0.
REQ-029 Send 0x55 with the stop bit held low -> FERR=1, NE=0; write STAT=0x4 -> FERR=0.
REQ-030 Pulse rx low for 4 clk -> no push and no flag set; a normal frame 0x7E immediately after is received correctly.
REQ-031 Assert reset in the middle of a frame -> all outputs are 0 next cycle and the FIFO is empty; a subsequent full frame 0x81 is received correctly.
